// File: rtl/patgen_pkg.sv
// Shared encodings and constants for the test-pattern generator.
package patgen_pkg;

  localparam int CNT_W = 11;

  typedef enum logic [1:0] {
    PAT_BARS   = 2'd0,
    PAT_GRID   = 2'd1,
    PAT_GRAD   = 2'd2,
    PAT_SCROLL = 2'd3
  } pat_e;

  typedef logic [23:0] rgb_t;

  // Indexed by bar number; entry 0 is the leftmost bar.
  localparam logic [7:0][23:0] BAR_COLOUR = {
    24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
    24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
  };

  localparam rgb_t RGB_WHITE = 24'hFFFFFF;
  localparam rgb_t RGB_RED   = 24'hFF0000;

endpackage

// File: rtl/patgen_bar.sv
// Colour-bar position counter: bar_idx advances every bw active pixels, saturating at 7.
// Registered, updates on each edge; free-running, no backpressure.
module patgen_bar
  import patgen_pkg::*;
(
  input  logic             DCLK,
  input  logic             DRST,
  input  logic [CNT_W-1:0] bw,
  input  logic             pre_de,
  output logic [2:0]       bar_idx
);

  logic [CNT_W-1:0] bar_pix;

  always_ff @(posedge DCLK) begin
    if (DRST) begin
      bar_pix <= '0;
      bar_idx <= '0;
    end else if (!pre_de) begin
      bar_pix <= '0;
      bar_idx <= '0;
    end else if ((bar_pix == (bw - CNT_W'(1))) && (bar_idx != 3'd7)) begin
      bar_idx <= bar_idx + 3'd1;
      bar_pix <= '0;
    end else begin
      bar_pix <= bar_pix + CNT_W'(1);
    end
  end

endmodule

// File: rtl/patgen_core.sv
// Test-pattern pixel generator; RGB/DE/syncs registered 1 cycle after preDE/syncs, no backpressure.
// Optional red frame border when PATGEN_BORDER_EN is defined.
module patgen_core
  import patgen_pkg::*;
#(
  parameter int BAR_W_INIT = 80,
  parameter int FRAME_W    = 8
) (
  input  logic       DCLK,
  input  logic       DRST,
  input  logic [1:0] PATSEL,
  input  logic       DSP_HSYNC_X,
  input  logic       DSP_VSYNC_X,
  input  logic       DSP_preDE,
  output logic [7:0] DSP_R,
  output logic [7:0] DSP_G,
  output logic [7:0] DSP_B,
  output logic       DSP_DE,
  output logic       DSP_HSYNC_OUT_X,
  output logic       DSP_VSYNC_OUT_X
);

  logic [CNT_W-1:0]   x_cnt;
  logic [CNT_W-1:0]   y_cnt;
  logic [CNT_W-1:0]   meas_w;
  logic [CNT_W-1:0]   bw;
  logic [FRAME_W-1:0] frame_cnt;
  logic [7:0]         frame_lo;
  logic [7:0]         scroll;
  pat_e               pat_q;
  logic               vs_d;
  logic               de_d;
  logic               line_end;
  logic               frame_start;
  logic [2:0]         bar_idx;
  rgb_t               pat_rgb;
  rgb_t               pix_rgb;

  assign line_end    = de_d & ~DSP_preDE;
  assign frame_start = vs_d & ~DSP_VSYNC_X;
  assign frame_lo    = 8'(frame_cnt);

  // Until a plausible line has been seen, fall back to the fixed bar width.
  assign bw = (meas_w >= CNT_W'(8)) ? (meas_w >> 3) : CNT_W'(BAR_W_INIT);

  patgen_bar u_bar (
    .DCLK    (DCLK),
    .DRST    (DRST),
    .bw      (bw),
    .pre_de  (DSP_preDE),
    .bar_idx (bar_idx)
  );

  always_comb begin
    pat_rgb = '0;
    scroll  = x_cnt[7:0] + frame_lo;
    case (pat_q)
      PAT_BARS:   pat_rgb = BAR_COLOUR[bar_idx];
      PAT_GRID:   pat_rgb = ((x_cnt[4:0] == 5'd0) || (y_cnt[4:0] == 5'd0)) ? RGB_WHITE : '0;
      PAT_GRAD:   pat_rgb = {3{x_cnt[7:0]}};
      PAT_SCROLL: pat_rgb = {scroll, y_cnt[7:0], scroll};
      default:    pat_rgb = '0;
    endcase
  end

`ifdef PATGEN_BORDER_EN
  logic [CNT_W-1:0] meas_h;
  logic             border;

  // Right and bottom edges are unknown until one line/frame has been measured.
  assign border = (x_cnt == '0) || (y_cnt == '0) ||
                  ((meas_w != '0) && (x_cnt == (meas_w - CNT_W'(1)))) ||
                  ((meas_h != '0) && (y_cnt == (meas_h - CNT_W'(1))));
  assign pix_rgb = border ? RGB_RED : pat_rgb;

  always_ff @(posedge DCLK) begin
    if (DRST) begin
      meas_h <= '0;
    end else if (frame_start) begin
      meas_h <= y_cnt;
    end
  end
`else
  assign pix_rgb = pat_rgb;
`endif

  always_ff @(posedge DCLK) begin
    if (DRST) begin
      x_cnt           <= '0;
      y_cnt           <= '0;
      meas_w          <= '0;
      frame_cnt       <= '0;
      pat_q           <= PAT_BARS;
      vs_d            <= 1'b1;
      de_d            <= 1'b0;
      DSP_R           <= '0;
      DSP_G           <= '0;
      DSP_B           <= '0;
      DSP_DE          <= 1'b0;
      DSP_HSYNC_OUT_X <= 1'b1;
      DSP_VSYNC_OUT_X <= 1'b1;
    end else begin
      vs_d  <= DSP_VSYNC_X;
      de_d  <= DSP_preDE;
      x_cnt <= DSP_preDE ? (x_cnt + CNT_W'(1)) : '0;
      if (line_end) begin
        meas_w <= x_cnt;
      end
      // Frame start takes priority over the line-end increment.
      if (frame_start) begin
        y_cnt     <= '0;
        pat_q     <= pat_e'(PATSEL);
        frame_cnt <= frame_cnt + FRAME_W'(1);
      end else if (line_end) begin
        y_cnt <= y_cnt + CNT_W'(1);
      end
      DSP_DE               <= DSP_preDE;
      DSP_HSYNC_OUT_X      <= DSP_HSYNC_X;
      DSP_VSYNC_OUT_X      <= DSP_VSYNC_X;
      {DSP_R, DSP_G, DSP_B} <= DSP_preDE ? pix_rgb : '0;
    end
  end

endmodule
